alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_unit.sv | 183 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Handshaked execute-stage ALU: single-cycle logic/arithmetic ops, plus
// shifts that move one bit per cycle. Responses are held until OutReady.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    // Returns {overflow, result}; unknown opcodes yield zero with no overflow.
    function automatic logic [WIDTH:0] alu_single(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [3:0]       op
    );
        logic [WIDTH-1:0] res;
        logic             ovf;
        res = {WIDTH{1'b0}};
        ovf = 1'b0;
        case (op)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_ADD: begin
                res = a + b;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res = a - b;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR: res = ~(a | b);
            default: begin
                res = {WIDTH{1'b0}};
                ovf = 1'b0;
            end
        endcase
        return {ovf, res};
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        logic r;
        case (op)
            OP_SLL, OP_SRL, OP_SRA: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] shift_one(
        input logic [WIDTH-1:0] val,
        input logic [3:0]       op
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = {val[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, val[WIDTH-1:1]};
            OP_SRA:  r = {val[WIDTH-1], val[WIDTH-1:1]};
            default: r = val;
        endcase
        return r;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   single_s;
    logic [WIDTH-1:0] shifted_s;

    assign single_s  = alu_single(A, B, ALUControl);
    assign shifted_s = shift_one(result_q, op_q);

    // Next-state and datapath: result_q doubles as the shift register during SHIFT.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (InValid) begin
                    op_d = ALUControl;
                    if (is_shift(ALUControl)) begin
                        ovf_d    = 1'b0;
                        result_d = A;
                        cnt_d    = B[4:0];
                        if (B[4:0] == 5'd0) begin
                            zero_d  = (A == {WIDTH{1'b0}});
                            state_d = ST_DONE;
                        end else begin
                            zero_d  = 1'b0;
                            state_d = ST_SHIFT;
                        end
                    end else begin
                        result_d = single_s[WIDTH-1:0];
                        ovf_d    = single_s[WIDTH];
                        zero_d   = (single_s[WIDTH-1:0] == {WIDTH{1'b0}});
                        cnt_d    = 5'd0;
                        state_d  = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                result_d = shifted_s;
                cnt_d    = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    zero_d  = (shifted_s == {WIDTH{1'b0}});
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (OutReady) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= 4'b0000;
            cnt_q    <= 5'd0;
            result_q <= {WIDTH{1'b0}};
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign InReady  = (state_q == ST_IDLE);
    assign OutValid = (state_q == ST_DONE);
    assign Result   = result_q;
    assign Zero     = zero_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver queues hand-computed
// responses, an independent monitor checks each one as OutValid rises.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [3:0]  ALUControl = 4'b0000;
    logic        OutValid;
    logic        OutReady = 1'b1;
    logic [31:0] Result;
    logic        Zero;
    logic        Overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        o;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .InValid(InValid), .InReady(InReady),
        .A(A), .B(B), .ALUControl(ALUControl),
        .OutValid(OutValid), .OutReady(OutReady),
        .Result(Result), .Zero(Zero), .Overflow(Overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez, input logic eo, input int elat);
        exp_t e;
        int   n;
        @(negedge clk);
        ALUControl = op;
        A = a;
        B = b;
        InValid = 1'b1;
        n = 0;
        while (!InReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!InReady) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got InReady=0 want InReady=1 within 200 cycles");
            InValid = 1'b0;
        end else begin
            e.r = er; e.z = ez; e.o = eo; e.lat = elat; e.acc = cyc + 1;
            sb.push_back(e);
            @(negedge clk);
            InValid = 1'b0;
            A = 32'hDEAD_BEEF;
            B = 32'h0000_0003;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || OutValid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb.size(), 32'd0);
    endtask

    // Monitor: compare on the first cycle of each response, then check it stays frozen.
    initial begin : monitor
        exp_t        e;
        logic        popped;
        logic [31:0] held;
        popped = 1'b0;
        held = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                popped = 1'b0;
            end else if (OutValid) begin
                if (!popped) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_response: got Result=%h want no response", Result);
                    end else begin
                        e = sb.pop_front();
                        chk("result", Result, e.r);
                        chk("zero", {31'd0, Zero}, {31'd0, e.z});
                        chk("overflow", {31'd0, Overflow}, {31'd0, e.o});
                        chk("latency", cyc - e.acc + 1, e.lat);
                    end
                    chk("zero_matches_result", {31'd0, Zero}, {31'd0, (Result == 32'd0)});
                    held = Result;
                    popped = 1'b1;
                end else begin
                    chk("held_result", Result, held);
                end
            end else begin
                popped = 1'b0;
            end
        end
    end

    initial begin : stimulus
        #1;
        chk("rst_inready", {31'd0, InReady}, 32'd1);
        chk("rst_outvalid", {31'd0, OutValid}, 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_zero", {31'd0, Zero}, 32'd0);
        chk("rst_overflow", {31'd0, Overflow}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        issue(4'b0010, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0, 1'b0, 1);
        issue(4'b0110, 32'h0000_0030, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 1);
        issue(4'b0110, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1);
        issue(4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
        issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1);
        issue(4'b1100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
        issue(4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1);
        drain();

        issue(4'b1000, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 32);
        issue(4'b1010, 32'hF000_0000, 32'd4, 32'hFF00_0000, 1'b0, 1'b0, 5);
        issue(4'b1001, 32'hF000_0000, 32'd4, 32'h0F00_0000, 1'b0, 1'b0, 5);
        issue(4'b1000, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b0, 1'b0, 1);
        issue(4'b1001, 32'h0000_0001, 32'd1, 32'h0000_0000, 1'b1, 1'b0, 2);
        drain();

        OutReady = 1'b0;
        issue(4'b0000, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 1'b1, 1'b0, 1);
        fork
            issue(4'b0001, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_inready", {31'd0, InReady}, 32'd0);
                    chk("stall_outvalid", {31'd0, OutValid}, 32'd1);
                    chk("stall_result", Result, 32'd0);
                    chk("stall_zero", {31'd0, Zero}, 32'd1);
                end
                OutReady = 1'b1;
                @(posedge clk);
                #1;
                chk("inready_after_handshake", {31'd0, InReady}, 32'd1);
            end
        join
        drain();

        issue(4'b1111, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1);
        issue(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1);
        drain();

        issue(4'b1001, 32'h8000_0000, 32'd20, 32'h0000_0800, 1'b0, 1'b0, 21);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midop_rst_outvalid", {31'd0, OutValid}, 32'd0);
        chk("midop_rst_result", Result, 32'd0);
        chk("midop_rst_inready", {31'd0, InReady}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            chk("no_resp_after_rst", {31'd0, OutValid}, 32'd0);
        end
        issue(4'b0010, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 1);
        drain();

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
